// File: rtl/control_fsm_if.sv
// control_fsm_if: instruction- and data-memory handshake bundle of the sequencer
//   master (sequencer): drives imem_req, imem_addr, instr_load, dmem_req, dmem_we
//   slave  (memories) : drives imem_ack, dmem_ack
interface control_fsm_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic                instr_load;
    logic                dmem_req;
    logic                dmem_we;
    logic                dmem_ack;

    modport master (
        output imem_req, imem_addr, instr_load, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, instr_load, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32 sequencer (fetch/decode/execute/memory/writeback), owns pc
//   clk, rst (sync, active-low)       clock and reset
//   register_arith .. opcode_valid    decoder class flags, sampled in DECODE
//   branch_taken, jump_target         branch result and target, sampled in WRITEBACK
//   bus (control_fsm_if.master)       imem/dmem handshakes and instr_load
//   rf_we, wb_sel, pc, retire, halted sequencer outputs
//   CONTROL_FSM_ILLEGAL_HALT_EN       when defined, an illegal opcode halts instead of acting as a NOP
module control_fsm #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                register_arith,
    input  logic                immediate_arith,
    input  logic                load,
    input  logic                store,
    input  logic                branch,
    input  logic                immediate_jump,
    input  logic                register_jump,
    input  logic                load_upper,
    input  logic                load_upper_pc,
    input  logic                environment,
    input  logic                opcode_valid,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] jump_target,
    control_fsm_if.master       bus,
    output logic                rf_we,
    output logic [1:0]          wb_sel,
    output logic [PC_WIDTH-1:0] pc,
    output logic                retire,
    output logic                halted
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;

    typedef struct packed {
        logic ld;
        logic st;
        logic br;
        logic jmp;
        logic rf;
    } cls_t;

    state_t              state, state_nxt;
    cls_t                cls, cls_dec;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                imem_req_d, instr_load_d, dmem_req_d, dmem_we_d;
    logic                rf_we_d, retire_d, halted_d;
    logic [1:0]          wb_sel_d;
    logic                unused_lsbs;

    // targets are word aligned, so the two low bits of jump_target are dropped
    assign unused_lsbs = ^jump_target[1:0];

    // an illegal opcode latches an empty class so it behaves as a NOP in WRITEBACK
    always_comb begin
        cls_dec     = '0;
        cls_dec.ld  = load;
        cls_dec.st  = store;
        cls_dec.br  = branch;
        cls_dec.jmp = immediate_jump | register_jump;
        cls_dec.rf  = register_arith | immediate_arith | load | immediate_jump
                    | register_jump | load_upper | load_upper_pc;
        if (!opcode_valid)
            cls_dec = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == DECODE)
            cls <= cls_dec;
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        imem_req_d   = 1'b0;
        instr_load_d = 1'b0;
        dmem_req_d   = 1'b0;
        dmem_we_d    = 1'b0;
        rf_we_d      = 1'b0;
        wb_sel_d     = 2'd0;
        retire_d     = 1'b0;
        halted_d     = 1'b0;
        case (state)
            FETCH: begin
                imem_req_d   = 1'b1;
                instr_load_d = bus.imem_ack;
                state_nxt    = bus.imem_ack ? DECODE : FETCH;
            end
            DECODE: begin
`ifdef CONTROL_FSM_ILLEGAL_HALT_EN
                state_nxt = environment ? HALT : !opcode_valid ? HALT : EXECUTE;
`else
                state_nxt = environment ? HALT : !opcode_valid ? WRITEBACK : EXECUTE;
`endif
            end
            EXECUTE: state_nxt = (cls.ld | cls.st) ? MEMORY : WRITEBACK;
            MEMORY: begin
                dmem_req_d = 1'b1;
                dmem_we_d  = cls.st;
                state_nxt  = bus.dmem_ack ? WRITEBACK : MEMORY;
            end
            WRITEBACK: begin
                retire_d  = 1'b1;
                rf_we_d   = cls.rf;
                wb_sel_d  = cls.ld ? 2'd1 : cls.jmp ? 2'd2 : 2'd0;
                pc_nxt    = (cls.jmp | (cls.br & branch_taken))
                          ? {jump_target[PC_WIDTH-1:2], 2'b00}
                          : pc + PC_WIDTH'(4);
                state_nxt = FETCH;
            end
            HALT: halted_d = 1'b1;
            default: state_nxt = FETCH;
        endcase
    end

    // reset is synchronous, so outputs are masked by rst directly while it is held low
    assign bus.imem_req   = rst & imem_req_d;
    assign bus.imem_addr  = pc;
    assign bus.instr_load = rst & instr_load_d;
    assign bus.dmem_req   = rst & dmem_req_d;
    assign bus.dmem_we    = rst & dmem_we_d;
    assign rf_we          = rst & rf_we_d;
    assign wb_sel         = rst ? wb_sel_d : 2'd0;
    assign retire         = rst & retire_d;
    assign halted         = rst & halted_d;
endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle instruction sequencer for the single-issue RV32 core. It owns the program counter and steps each instruction through fetch, decode, execute, memory and writeback. It consumes the instruction-class flags from the decoder and drives the instruction-memory and data-memory handshakes, the register-file write enable and the writeback mux select.

## Interface

Parameters:
- PC_WIDTH, 32, width of the program counter and memory addresses
- RESET_PC, 32'h0000_0000, PC value loaded by reset

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- register_arith, immediate_arith, load, store, branch, immediate_jump, register_jump, load_upper, load_upper_pc, environment, opcode_valid  in  1 each  decoder class flags for the instruction register contents
- branch_taken  in  1  branch comparator result
- jump_target  in  PC_WIDTH  branch/jump target from the ALU
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_WIDTH  fetch address, always equal to pc
- imem_ack  in  1  fetch data valid this cycle
- instr_load  out  1  capture instruction into the instruction register
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a store
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = pc+4
- pc  out  PC_WIDTH  current program counter
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  sequencer is parked in HALT

## Operation

- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. Outputs are decoded from the state register (Moore), except instr_load.
- **FETCH:** imem_req=1. Hold the state until imem_ack. In the ack cycle, instr_load=1 and the next state is DECODE.
- **DECODE:** one cycle. Class flags are latched into an internal class register. The next state is chosen as follows:
  - environment: HALT.
  - !opcode_valid: see Configuration.
  - otherwise: EXECUTE.
- **EXECUTE:** one cycle. load or store goes to MEMORY; all other classes go to WRITEBACK.
- **MEMORY:** dmem_req=1, with dmem_we=1 for store and 0 for load. Hold the state until dmem_ack, then go to WRITEBACK.
- **WRITEBACK:** one cycle. retire=1, PC updates, then go to FETCH.
  - rf_we=1 for register_arith, immediate_arith, load, immediate_jump, register_jump, load_upper, load_upper_pc. rf_we=0 for store, branch and NOP.
  - wb_sel: load gives 1; either jump gives 2; otherwise 0.
  - Next pc: either jump, or branch with branch_taken, loads {jump_target[PC_WIDTH-1:2], 2'b00}. Otherwise pc+4 modulo 2^PC_WIDTH, so 0xFFFFFFFC wraps to 0x0.
- **HALT:** halted=1, no requests, pc frozen. The only exit is reset.
- An imem_ack outside FETCH or a dmem_ack outside MEMORY is ignored.

## Timing

- **Reset** (rst=0 at a clk edge): state becomes FETCH and pc becomes RESET_PC. While rst=0, all outputs except pc are forced to 0. The first imem_req appears in the first cycle with rst=1.
- **Reset mid-operation:** it takes effect at the next edge from any state, including MEMORY with dmem_ack high. The pending access is abandoned and the instruction does not retire.
- **Latency:** a non-memory instruction with zero-wait ack takes 4 cycles from first imem_req to the retire cycle inclusive. A memory instruction takes 5 cycles. Each wait cycle on imem_ack or dmem_ack adds one cycle.
- **Signal timing:**
  - The class flags only need to be valid in the DECODE cycle.
  - branch_taken and jump_target are sampled in the WRITEBACK cycle.
  - The new pc is visible in the following FETCH cycle.

## Configuration

- Macro: CONTROL_FSM_ILLEGAL_HALT_EN.
- **Defined:** !opcode_valid in DECODE goes to HALT. No retire is issued and pc stays at the faulting address.
- **Undefined:** an illegal instruction is a NOP. DECODE goes directly to WRITEBACK with rf_we=0, retire=1 and pc+4.

## Test plan

- **Reset release:** hold rst=0 for 3 cycles, then release. Expect imem_req=1 and imem_addr=0x0 in the first cycle after release, with all other outputs 0 during reset.
- **addi with zero-wait imem_ack at pc 0x0:** expect retire in cycle 4 with rf_we=1 and wb_sel=0, then imem_addr=0x4.
- **lw with dmem_ack delayed 3 cycles:** expect dmem_req=1 and dmem_we=0 for 4 cycles, then retire in cycle 8 with rf_we=1 and wb_sel=1.
- **Branches and jumps:**
  - beq taken, jump_target=0x103: pc becomes 0x100 with rf_we=0.
  - Same beq not taken: pc becomes pc+4.
  - jal at pc 0x20: rf_we=1, wb_sel=2.
- **PC wrap:** add at pc 0xFFFFFFFC, then pc becomes 0x0.
- **Illegal opcode then ecall:**
  - Macro defined: halted=1 and no imem_req for 20 cycles.
  - Macro undefined: retire with rf_we=0 and pc+4; the ecall then halts.
- **Reset mid-MEMORY:** assert rst=0 while dmem_req=1. Expect no retire, then FETCH at RESET_PC.
